// File: rtl/fp_alu_sequencer.sv
// Issue/capture stage in front of the combinational FP ALU.
// Queues requests, holds ALU inputs for a settle time, then captures and classifies.
module fp_alu_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [1:0]                 in_op,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [1:0]                 alu_opcode,
  input  logic [31:0]                alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } req_t;

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic          w_push;
  logic          w_pop;
  req_t          w_head;
  logic [7:0]    w_exp;
  logic [22:0]   w_man;
  logic          w_illegal;
  logic [3:0]    w_flags;

  assign w_head   = r_mem[r_rp];
  // DEPTH is a power of two, so the count MSB alone marks full
  assign in_ready = rst_n & ~r_count[AW];
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_count != '0) &
                    ((r_state == S_IDLE) |
                     ((r_state == S_DONE) & out_ready));

  assign w_exp     = alu_result[30:23];
  assign w_man     = alu_result[22:0];
  assign w_illegal = (alu_opcode == 2'b11);

  always_comb begin
    w_flags = 4'b0000;
    unique case (1'b1)
      w_illegal: w_flags = 4'b1001;
      default: begin
        w_flags[2] = (w_exp == 8'hFF) & (w_man != '0);
        w_flags[1] = (w_exp == 8'hFF) & (w_man == '0);
        w_flags[0] = (w_exp == 8'h00) & (w_man == '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= '{a: in_a, b: in_b, op: in_op};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 2'b00;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_pop) begin
        alu_a      <= w_head.a;
        alu_b      <= w_head.b;
        alu_opcode <= w_head.op;
        r_cnt      <= CW'(SETTLE - 1);
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            out_result <= w_illegal ? 32'h0 : alu_result;
            out_flags  <= w_flags;
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= w_pop ? S_WAIT : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_state != S_IDLE) | (r_count != '0);
endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Scoreboard bench for fp_alu_sequencer with a keyed ALU stub.
// Expected results come from a flag/result model of the capture rules.
module tb_fp_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic        busy;

  always #5 clk = ~clk;

  fp_alu_sequencer #(.DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .count(count), .busy(busy)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] stub[logic [65:0]];
  logic [65:0] w_key;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rnd_mode = 0;
  bit          ready_cfg = 1;
  logic        rnd_bit = 1'b1;
  bit          tp_mode = 0;
  int          lastpop = -1;
  bit          holding = 0;
  logic [31:0] held_r;
  logic [3:0]  held_f;

  always_comb begin
    w_key = {alu_a, alu_b, alu_opcode};
    alu_result = 32'hDEADBEEF;
    if (stub.exists(w_key)) alu_result = stub[w_key];
  end

  assign out_ready = rnd_mode ? rnd_bit : ready_cfg;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  function automatic logic [3:0] model_flags(input logic [1:0] op,
                                             input logic [31:0] r);
    int unsigned e;
    int unsigned m;
    if (op == 2'b11) return 4'b1001;
    e = (r >> 23) & 32'hFF;
    m = r & 32'h007F_FFFF;
    return {1'b0, (e == 255) && (m != 0), (e == 255) && (m == 0),
            (e == 0) && (m == 0)};
  endfunction

  function automatic logic [31:0] model_res(input logic [1:0] op,
                                            input logic [31:0] r);
    return (op == 2'b11) ? 32'h0 : r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each downstream handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (holding) begin
        chk("stall_result", out_result, held_r);
        chk("stall_flags", 32'(out_flags), 32'(held_f));
      end
      if (out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none",
                   out_result);
        end else begin
          e = sbq.pop_front();
          chk("result", out_result, e.r);
          chk("flags", 32'(out_flags), 32'(e.f));
        end
        if (tp_mode && lastpop >= 0) chk("interval", 32'(cyc - lastpop), 3);
        lastpop = cyc;
        holding = 0;
      end else begin
        holding = 1;
        held_r = out_result;
        held_f = out_flags;
      end
    end else begin
      holding = 0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [31:0] res,
                      output int acc);
    bit ok;
    ok = 0;
    stub[{a, b, op}] = res;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    acc = -1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    sbq.push_back('{model_res(op, res), model_flags(op, res)});
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int acc, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end else begin
      chk(name, 32'(cyc - acc), 3);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [31:0] sp [9];
    sp = '{32'h7F800001, 32'hFFFFFFFF, 32'h7F800000, 32'hFF800000,
           32'h00000000, 32'h80000000, 32'h00000001, 32'h007FFFFF,
           32'h3F800000};
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", 32'(alu_opcode), 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", 32'(out_flags), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    send(32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, acc);
    wait_valid(acc, "latency_add");
    chk("alu_opcode_add", 32'(alu_opcode), 0);
    chk("alu_a_add", alu_a, 32'h3F800000);
    chk("alu_b_add", alu_b, 32'h40000000);
    drain();

    send(32'h1, 32'h2, 2'b01, 32'h7FC00000, acc);
    send(32'h3, 32'h4, 2'b10, 32'hFF800000, acc);
    send(32'h5, 32'h6, 2'b00, 32'h80000000, acc);
    send(32'h7, 32'h8, 2'b01, 32'h00000001, acc);
    drain();

    send(32'hAAAA0000, 32'h5555FFFF, 2'b11, 32'h12345678, acc);
    wait_valid(acc, "latency_illegal");
    chk("alu_opcode_ill", 32'(alu_opcode), 3);
    chk("illegal_result", out_result, 0);
    drain();

    ready_cfg = 0;
    for (int i = 0; i < 5; i++)
      send(32'h1000 + i, 32'h2000 + i, 2'(i % 3), 32'h40000000 + i, acc);
    @(negedge clk);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    stub[{32'h9999, 32'h9999, 2'b00}] = 32'h1;
    in_a = 32'h9999;
    in_b = 32'h9999;
    in_op = 2'b00;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_hold_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("full_count_hold", 32'(count), 4);
    ready_cfg = 1;
    drain();

    tp_mode = 1;
    lastpop = -1;
    for (int i = 0; i < 8; i++)
      send(32'h3000 + i, 32'h4000 + i, 2'(i % 4), sp[i], acc);
    drain();
    tp_mode = 0;

    send(32'h5000, 32'h1, 2'b00, 32'h1, acc);
    send(32'h5001, 32'h1, 2'b01, 32'h2, acc);
    send(32'h5002, 32'h1, 2'b10, 32'h3, acc);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 2);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("rst_forces_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 0);

    rnd_mode = 1;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] r;
      r = ($urandom_range(0, 3) == 0) ? $urandom : sp[$urandom_range(0, 8)];
      send($urandom, $urandom, 2'($urandom_range(0, 3)), r, acc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rnd_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_alu_sequencer.md
Name: fp_alu_sequencer

Overview:
- Issue/capture stage directly upstream of the combinational floating-point ALU (ports A, B, opcode, result).
- Accepts operation requests (two IEEE-754 single-precision operands plus 2-bit opcode) over a valid/ready interface and buffers them in a small FIFO.
- Drives one request at a time onto registered ALU inputs, waits a fixed settle time, then captures the ALU result with classification flags and presents it downstream over valid/ready.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, >= 2.
- SETTLE, 2, cycles the ALU inputs are held before result capture; >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- in_a  in  32  operand A, IEEE-754 single.
- in_b  in  32  operand B, IEEE-754 single.
- in_op  in  2  opcode: 00 add, 01 mul, 10 div, 11 illegal.
- alu_a  out  32  registered, to ALU A.
- alu_b  out  32  registered, to ALU B.
- alu_opcode  out  2  registered, to ALU opcode.
- alu_result  in  32  from ALU result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_result  out  32  captured result.
- out_flags  out  4  {illegal, nan, inf, zero}.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  high when state != IDLE or count != 0.

Behaviour:
- Reset (rst_n low at clk edge):
  - FIFO emptied; state IDLE; settle counter 0.
  - alu_a, alu_b, out_result = 0; alu_opcode = 00; out_flags = 0; out_valid = 0.
  - count = 0; busy = 0; in_ready forced 0 while rst_n is low.
  - Reset mid-operation discards all queued and in-flight requests; no partial result is emitted.
- FIFO:
  - in_ready = !full (count < DEPTH).
  - Push on in_valid & in_ready. Pop only by the FSM issue action.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - When full, in_ready = 0 even if a pop occurs in that cycle (no fall-through).
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, count != 0: issue = load alu_a/alu_b/alu_opcode from FIFO head, pop, cnt <= SETTLE-1, go to WAIT.
  - IDLE, count == 0: stay in IDLE.
  - WAIT, cnt != 0: cnt <= cnt-1.
  - WAIT, cnt == 0: capture alu_result into out_result, set out_flags, out_valid <= 1, go to DONE.
  - DONE, out_valid & !out_ready: hold; out_result and out_flags stable.
  - DONE, out_ready, count != 0: out_valid <= 0 and issue next request in the same edge; go to WAIT (back-to-back).
  - DONE, out_ready, count == 0: out_valid <= 0; go to IDLE.
- Latency:
  - Request accepted at edge E into an idle, empty block: out_valid rises after edge E+SETTLE+1 (3 cycles at default).
  - Sustained throughput: one result per SETTLE+1 cycles with out_ready held high.
- Illegal opcode 11:
  - Still issued to the ALU and takes the same latency.
  - Captured out_result forced to 0x00000000; out_flags = 4'b1001.
- Flags on captured value (legal opcodes), with e = bits[30:23] and m = bits[22:0]:
  - nan: e == 8'hFF and m != 0.
  - inf: e == 8'hFF and m == 0.
  - zero: e == 0 and m == 0, either sign; denormals are not zero.
  - illegal: 0.
- alu_* outputs hold their last issued value while idle.

Test Plan:
- Reset then single request: in_a=0x3F800000, in_b=0x40000000, in_op=00; ALU stub returns 0x40400000 -> out_valid 3 cycles after accept, out_result=0x40400000, out_flags=0000; alu_opcode=00.
- Classification: stub returns 0x7FC00000, 0xFF800000, 0x80000000, 0x00000001 on four requests -> flags 0100, 0010, 0001, 0000 respectively.
- Illegal op: in_op=11, stub returns 0x12345678 -> out_result=0x00000000, out_flags=1001, same 3-cycle latency.
- Fill/backpressure: out_ready=0, push 6 requests back-to-back -> 1 issued, count reaches 4, in_ready=0; then release out_ready -> all 5 results emitted in order, out_result stable while stalled.
- Throughput: 8 queued requests, out_ready=1 -> out_valid pulses every 3 cycles, order preserved across pointer wrap.
- Reset mid-WAIT with 2 queued -> next cycle out_valid=0, count=0, busy=0, and no stale result emitted afterwards.
